// File: rtl/vec_pipe_pkg.sv
// Shared types and constants for the vector pipeline hazard/forwarding slice.
//   fwd_sel_t    : forward select for Execute operands
//   stage_info_t : destination record carried by each shadow stage
//   src_info_t   : source record, only kept for the Execute shadow stage
//   fwdSelect()  : youngest-producer-wins forward select for one operand
package vec_pipe_pkg;

    localparam int DEF_R = 6;
    localparam int DEF_N = 8;
    localparam int DEF_A = 4;
    // Register addresses are zero-extended to this width inside the shadow
    // records, so any A up to MAX_A shares the same struct layout.
    localparam int MAX_A = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [MAX_A-1:0] wa3;
        logic             regWrite;
        logic             memToReg;
    } stage_info_t;

    typedef struct packed {
        logic [MAX_A-1:0] ra1;
        logic [MAX_A-1:0] ra2;
        logic             use1;
        logic             use2;
    } src_info_t;

    // A load still in M has no data yet, so it never forwards from M.
    // M is checked first: it holds the younger producer.
    function automatic fwd_sel_t fwdSelect(input logic useE,
                                           input logic [MAX_A-1:0] raE,
                                           input stage_info_t m,
                                           input stage_info_t w);
        if (useE && m.valid && m.regWrite && !m.memToReg && m.wa3 == raE)
            return FWD_MEM;
        if (useE && w.valid && w.regWrite && w.wa3 == raE)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/vec_fwd_mux.sv
// Three-way operand mux for R lanes of N bits; all lanes share one select.
// Ports:
//   sel     : forward select (FWD_RF / FWD_WB / FWD_MEM)
//   rfData  : operand from the ID/EX register
//   wbData  : W-stage result
//   memData : M-stage ALU result
//   y       : selected operand
module vec_fwd_mux
    import vec_pipe_pkg::*;
#(
    parameter int R = DEF_R,
    parameter int N = DEF_N
) (
    input  fwd_sel_t       sel,
    input  logic [R*N-1:0] rfData,
    input  logic [R*N-1:0] wbData,
    input  logic [R*N-1:0] memData,
    output logic [R*N-1:0] y
);

    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        y = rfData;
        case (sel)
            FWD_WB:  y = wbData;
            FWD_MEM: y = memData;
            default: y = rfData;
        endcase
    end

endmodule

// File: rtl/vec_hazard_unit.sv
// Hazard and forwarding unit for the five-stage vector pipeline.
// Keeps an E/M/W shadow record of destination registers and produces
// load-use stalls, E bubbles and per-operand forwarding into Execute.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   ValidD, RA1D, RA2D, Use1D, Use2D, WA3D, RegWriteD, MemtoRegD : Decode info
//   BranchFlushE              : flush of the instruction entering E
//   RD1D, RD2D                : regfile read data
//   RD1E, RD2E                : operands from the ID/EX register
//   ALUOutputM, ResultW       : M and W stage results
//   RD1Dq, RD2Dq              : Decode operands (optionally WB-bypassed)
//   SrcAE, SrcBE              : forwarded Execute operands
//   FwdAE, FwdBE              : forward selects
//   StallF, StallD, FlushE    : pipeline control
//   StallCount                : saturating stall-cycle counter
// Build option: define VHU_WB_BYPASS_EN to bypass ResultW into the Decode
// operands instead of stalling on a W-write/D-read address match.
module vec_hazard_unit
    import vec_pipe_pkg::*;
#(
    parameter int R   = DEF_R,
    parameter int N   = DEF_N,
    parameter int A   = DEF_A,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ValidD,
    input  logic [A-1:0]   RA1D,
    input  logic [A-1:0]   RA2D,
    input  logic           Use1D,
    input  logic           Use2D,
    input  logic [A-1:0]   WA3D,
    input  logic           RegWriteD,
    input  logic           MemtoRegD,
    input  logic           BranchFlushE,
    input  logic [R*N-1:0] RD1D,
    input  logic [R*N-1:0] RD2D,
    input  logic [R*N-1:0] RD1E,
    input  logic [R*N-1:0] RD2E,
    input  logic [R*N-1:0] ALUOutputM,
    input  logic [R*N-1:0] ResultW,
    output logic [R*N-1:0] RD1Dq,
    output logic [R*N-1:0] RD2Dq,
    output logic [R*N-1:0] SrcAE,
    output logic [R*N-1:0] SrcBE,
    output logic [1:0]     FwdAE,
    output logic [1:0]     FwdBE,
    output logic           StallF,
    output logic           StallD,
    output logic           FlushE,
    output logic [SCW-1:0] StallCount
);

    stage_info_t      dStage, eStage, mStage, wStage;
    src_info_t        dSrc, eSrc;
    logic [MAX_A-1:0] ra1x, ra2x;
    logic             loadUse, wbHazard, stall;
    fwd_sel_t         fwdA, fwdB;

    assign ra1x   = MAX_A'(RA1D);
    assign ra2x   = MAX_A'(RA2D);
    assign dStage = '{valid: ValidD, wa3: MAX_A'(WA3D), regWrite: RegWriteD, memToReg: MemtoRegD};
    assign dSrc   = '{ra1: ra1x, ra2: ra2x, use1: Use1D, use2: Use2D};

    assign loadUse = eStage.valid & eStage.regWrite & eStage.memToReg & ValidD &
                     ((Use1D & (ra1x == eStage.wa3)) | (Use2D & (ra2x == eStage.wa3)));

`ifdef VHU_WB_BYPASS_EN
    // The W result is steered straight into the Decode operands, so a
    // W-write/D-read match needs no stall.
    assign wbHazard = 1'b0;
    assign RD1Dq = (wStage.valid && wStage.regWrite && wStage.wa3 == ra1x) ? ResultW : RD1D;
    assign RD2Dq = (wStage.valid && wStage.regWrite && wStage.wa3 == ra2x) ? ResultW : RD2D;
`else
    // The regfile does not return the value being written this cycle, so
    // Decode waits one cycle for the write to land.
    assign wbHazard = wStage.valid & wStage.regWrite & ValidD &
                      ((Use1D & (ra1x == wStage.wa3)) | (Use2D & (ra2x == wStage.wa3)));
    assign RD1Dq = RD1D;
    assign RD2Dq = RD2D;
`endif

    // A flush discards the instruction entering E anyway, so it wins over a stall.
    assign stall  = (loadUse | wbHazard) & ~BranchFlushE;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    assign fwdA  = fwdSelect(eSrc.use1, eSrc.ra1, mStage, wStage);
    assign fwdB  = fwdSelect(eSrc.use2, eSrc.ra2, mStage, wStage);
    assign FwdAE = fwdA;
    assign FwdBE = fwdB;

    vec_fwd_mux #(.R(R), .N(N)) uFwdA (
        .sel     (fwdA),
        .rfData  (RD1E),
        .wbData  (ResultW),
        .memData (ALUOutputM),
        .y       (SrcAE)
    );

    vec_fwd_mux #(.R(R), .N(N)) uFwdB (
        .sel     (fwdB),
        .rfData  (RD2E),
        .wbData  (ResultW),
        .memData (ALUOutputM),
        .y       (SrcBE)
    );

    // NOTE: non-blocking assignments so W takes the old M and M the old E on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            eStage <= '0;
            eSrc   <= '0;
            mStage <= '0;
            wStage <= '0;
        end else begin
            wStage <= mStage;
            mStage <= eStage;
            if (!stall && !BranchFlushE) begin
                eStage <= dStage;
                eSrc   <= dSrc;
            end else begin
                eStage <= '0;
                eSrc   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            StallCount <= '0;
        else if (stall && StallCount != '1)
            StallCount <= StallCount + SCW'(1);
    end

endmodule
